axi_lite_cmd_master: RTL and testbench
======================================

Name: axi_lite_cmd_master

Overview:
Single-outstanding AXI4-Lite initiator. It converts a simple command/response handshake into AXI-Lite read or write transactions. It is the master-side counterpart of the DFR core's AXI-Lite config/memory port, used by on-chip sequencers and testbenches to load input samples and output weights, set the ctrl register, and read back DFR output memory. A watchdog converts a hung slave into an error response instead of a deadlock.

Parameters:
ADDR_WIDTH, 30, AXI address width; matches the slave's C_S_AXI_ADDR_WIDTH.
DATA_WIDTH, 32, AXI data width; only 32 is supported.
TIMEOUT_CYCLES, 1024, cycles a transaction may stay in an AXI phase before abort; 0 disables the watchdog.

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  DATA_WIDTH/8  write strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
rsp_timeout  out  1  response was produced by the watchdog
busy  out  1  state != IDLE
M_AXI_AWADDR out ADDR_WIDTH; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1
M_AXI_WDATA out DATA_WIDTH; M_AXI_WSTRB out DATA_WIDTH/8; M_AXI_WVALID out 1; M_AXI_WREADY in 1
M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1
M_AXI_ARADDR out ADDR_WIDTH; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1
M_AXI_RDATA in DATA_WIDTH; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE; all M_AXI_*VALID, BREADY, RREADY, rsp_valid, rsp_timeout and busy are 0; AXI address/data regs, rsp_rdata and rsp_resp are 0.
- rst asserted mid-transaction aborts immediately to the reset values. No response is issued.
- All outputs are registered, except cmd_ready and busy, which are decodes of the state register.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: when cmd_valid is high, the command is captured in the same cycle (cmd_ready=1).
  - Write: go to WR_REQ; AWVALID and WVALID both rise on the next cycle; aw_done and w_done are cleared.
  - Read: go to RD_REQ; ARVALID rises on the next cycle.
- WR_REQ: AW and W complete independently.
  - AWVALID&&AWREADY sets aw_done and drops AWVALID the next cycle. W is handled the same way with w_done.
  - Both handshakes may occur in the same cycle, in either order, or many cycles apart.
  - When both are done, go to WR_RESP with BREADY=1.
  - AWADDR and WDATA stay stable while their VALID is high.
- WR_RESP: on BVALID&&BREADY, capture BRESP into rsp_resp, set rsp_rdata=0, drop BREADY, go to RSP.
- RD_REQ: on ARVALID&&ARREADY, drop ARVALID, raise RREADY, go to RD_RESP.
- RD_RESP: on RVALID&&RREADY, capture RDATA and RRESP, drop RREADY, go to RSP.
- RSP: rsp_valid=1 and the rsp_* outputs are held until rsp_ready. On the rsp_valid&&rsp_ready cycle go to IDLE. The next command can be accepted on the following cycle.
- Zero-wait slave latency:
  - Write: cmd accept at cycle N, AW/W handshake at N+1, B handshake at N+2 earliest, rsp_valid at N+3.
  - Read: AR handshake at N+1, R handshake at N+2 earliest, rsp_valid at N+3.
- Watchdog:
  - The counter clears on every state transition and increments while in WR_REQ, WR_RESP, RD_REQ or RD_RESP.
  - When the count reaches TIMEOUT_CYCLES (with TIMEOUT_CYCLES != 0), all VALID/READY outputs drop and the FSM goes to RSP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
  - This abort deliberately violates AXI VALID persistence. After a timeout the slave must be reset before further use.
  - rsp_timeout clears when the next command is accepted.
- A handshake in the same cycle as watchdog expiry wins: normal progress, no timeout.
- cmd_valid outside IDLE is ignored, because cmd_ready=0.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter saturates and does not wrap.

Decomposition:
- Package dfr_axi_pkg holds:
  - the state enum (IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP);
  - response constants AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10;
  - DFR memory-window base constants: INPUT_MEM_BASE=30'h0040_0000, RES_OUT_MEM_BASE=30'h0080_0000, OUT_WEIGHT_MEM_BASE=30'h00C0_0000, DFR_OUT_MEM_BASE=30'h0100_0000.
- The watchdog reuses the existing counter module (en = in an AXI phase, rst = rst || state change). No other sub-module.

Test Plan:
- Write with a zero-wait slave: cmd_write=1, addr=30'h0040_0004, wdata=32'hDEAD_BEEF, wstrb=4'hF → AW and W handshake in the same cycle, BRESP=00, rsp_valid 3 cycles after accept, rsp_resp=00, rsp_rdata=0.
- Skewed write: slave holds AWREADY low for 5 cycles and asserts WREADY immediately → WVALID drops after 1 cycle, AWVALID held 6 cycles with stable AWADDR, exactly one B handshake, single response.
- Read: addr=30'h0100_0000, slave returns RDATA=32'h1234_5678 with RRESP=00 after 3 wait cycles → rsp_rdata=32'h1234_5678, rsp_resp=00, RREADY high only in RD_RESP.
- Response backpressure and error: BRESP=2'b10 with rsp_ready held low for 4 cycles → rsp_valid and rsp_resp=10 stable, cmd_ready=0 until the handshake, next cmd accepted the cycle after.
- Timeout: TIMEOUT_CYCLES=16, slave never asserts ARREADY → ARVALID drops at cycle 16, rsp_timeout=1, rsp_resp=10; a handshake arriving exactly at cycle 16 instead completes normally.
- Reset mid-write in WR_RESP → the next cycle has all VALID/READY=0, busy=0, no rsp_valid; a following read completes normally.

Source files
------------

// File: rtl/dfr_axi_pkg.sv
// Shared types and constants for the DFR AXI-Lite command master.
// Holds the FSM encoding, AXI response codes and the DFR memory-window bases.
package dfr_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RSP
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [29:0] INPUT_MEM_BASE      = 30'h0040_0000;
  localparam logic [29:0] RES_OUT_MEM_BASE    = 30'h0080_0000;
  localparam logic [29:0] OUT_WEIGHT_MEM_BASE = 30'h00C0_0000;
  localparam logic [29:0] DFR_OUT_MEM_BASE    = 30'h0100_0000;

  // States in which the watchdog is allowed to run.
  function automatic logic in_axi_phase(input state_t s);
    return (s == WR_REQ) || (s == WR_RESP) || (s == RD_REQ) || (s == RD_RESP);
  endfunction

endpackage

// File: rtl/axi_lite_cmd_master_counter.sv
// Saturating up-counter with synchronous clear; used as the transaction watchdog.
module axi_lite_cmd_master_counter #(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (en && cnt != MAX) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI read or write out,
// one response back. A watchdog turns a stalled AXI phase into a SLVERR response.
module axi_lite_cmd_master
  import dfr_axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 30,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            resp;
    logic                  timeout;
  } rsp_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic rsp_valid_q, rsp_valid_d;
  rsp_t rsp_q, rsp_d;

  logic [CNT_W-1:0] wd_cnt;
  logic             phase, expire, abort;
  logic             aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_ok, w_ok;

  assign phase  = in_axi_phase(state);
  assign expire = (TIMEOUT_CYCLES != 0) && phase && (wd_cnt == CNT_MAX);

  axi_lite_cmd_master_counter #(.WIDTH(CNT_W), .MAX(CNT_MAX)) u_wdog (
    .clk (clk),
    .rst (rst || (state_nxt != state)),
    .en  (phase),
    .cnt (wd_cnt)
  );

  assign aw_hs = awvalid_q && M_AXI_AWREADY;
  assign w_hs  = wvalid_q  && M_AXI_WREADY;
  assign b_hs  = bready_q  && M_AXI_BVALID;
  assign ar_hs = arvalid_q && M_AXI_ARREADY;
  assign r_hs  = rready_q  && M_AXI_RVALID;
  assign aw_ok = aw_done_q || aw_hs;
  assign w_ok  = w_done_q  || w_hs;

  always_comb begin
    state_nxt   = state;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    abort       = 1'b0;

    case (state)
      IDLE: if (cmd_valid) begin
        rsp_d.timeout = 1'b0;
        if (cmd_write) begin
          awaddr_d  = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_nxt = WR_REQ;
        end else begin
          araddr_d  = cmd_addr;
          arvalid_d = 1'b1;
          state_nxt = RD_REQ;
        end
      end
      WR_REQ: begin
        // AW and W retire independently; any handshake this cycle beats the watchdog.
        if (aw_hs) begin awvalid_d = 1'b0; aw_done_d = 1'b1; end
        if (w_hs)  begin wvalid_d  = 1'b0; w_done_d  = 1'b1; end
        if (aw_ok && w_ok) begin
          bready_d  = 1'b1;
          state_nxt = WR_RESP;
        end else if (expire && !aw_hs && !w_hs) begin
          abort = 1'b1;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          rsp_d.resp  = M_AXI_BRESP;
          rsp_d.rdata = '0;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_nxt   = RSP;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      RD_REQ: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_nxt = RD_RESP;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      RD_RESP: begin
        if (r_hs) begin
          rsp_d.rdata = M_AXI_RDATA;
          rsp_d.resp  = M_AXI_RRESP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_nxt   = RSP;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      RSP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Watchdog abort drops every handshake signal mid-phase; the slave needs a reset afterwards.
    if (abort) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rsp_d       = '{rdata: '0, resp: AXI_RESP_SLVERR, timeout: 1'b1};
      rsp_valid_d = 1'b1;
      state_nxt   = RSP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state       <= state_nxt;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign cmd_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_q.rdata;
  assign rsp_resp      = rsp_q.resp;
  assign rsp_timeout   = rsp_q.timeout;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench: a configurable AXI-Lite slave model, a response scoreboard fed by
// the stimulus and drained by an independent monitor, plus cycle-accurate timing checks.
module tb_axi_lite_cmd_master;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [29:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [29:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  axi_lite_cmd_master #(.ADDR_WIDTH(30), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0;

  // slave configuration and observations
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;
  int awv_cnt = 0, wv_cnt = 0, b_cnt = 0, arv_cnt = 0, r_cnt = 0;
  int awv_total = 0, wv_total = 0, arv_total = 0, rready_total = 0, b_hs_cnt = 0;
  int awaddr_moves = 0;
  int aw_hs_cyc = -1, w_hs_cyc = -1, b_hs_cyc = -1, ar_hs_cyc = -1;
  int rsp_first_cyc = -1, rsp_hs_cyc = -1;
  logic [29:0] awaddr_first = '0;
  logic        rsp_valid_prev = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL bench_time_limit: got still running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // AXI-Lite slave model: readies/valids change on the falling edge only.
  always @(negedge clk) begin
    if (rst) begin
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
      M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
      awv_cnt = 0; wv_cnt = 0; b_cnt = 0; arv_cnt = 0; r_cnt = 0;
    end else begin
      if (M_AXI_AWVALID) begin
        if (awv_cnt == 0) awaddr_first = M_AXI_AWADDR;
        else if (M_AXI_AWADDR != awaddr_first) awaddr_moves++;
        M_AXI_AWREADY = (awv_cnt >= aw_delay);
        awv_cnt++; awv_total++;
      end else begin
        M_AXI_AWREADY = 1'b0; awv_cnt = 0;
      end
      if (M_AXI_AWVALID && M_AXI_AWREADY) aw_hs_cyc = cyc;

      if (M_AXI_WVALID) begin
        M_AXI_WREADY = (wv_cnt >= w_delay);
        wv_cnt++; wv_total++;
      end else begin
        M_AXI_WREADY = 1'b0; wv_cnt = 0;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) w_hs_cyc = cyc;

      M_AXI_BRESP = bresp_cfg;
      if (M_AXI_BREADY) begin
        M_AXI_BVALID = (b_cnt >= b_delay);
        b_cnt++;
      end else begin
        M_AXI_BVALID = 1'b0; b_cnt = 0;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin b_hs_cnt++; b_hs_cyc = cyc; end

      if (M_AXI_ARVALID) begin
        M_AXI_ARREADY = (arv_cnt >= ar_delay);
        arv_cnt++; arv_total++;
      end else begin
        M_AXI_ARREADY = 1'b0; arv_cnt = 0;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) ar_hs_cyc = cyc;

      M_AXI_RDATA = rdata_cfg;
      M_AXI_RRESP = rresp_cfg;
      if (M_AXI_RREADY) begin
        M_AXI_RVALID = (r_cnt >= r_delay);
        r_cnt++; rready_total++;
      end else begin
        M_AXI_RVALID = 1'b0; r_cnt = 0;
      end
    end
  end

  // Response monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && !rsp_valid_prev) rsp_first_cyc = cyc;
      rsp_valid_prev = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        rsp_hs_cyc = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
        end
      end
    end else begin
      rsp_valid_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [29:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int acc);
    logic rdy;
    int   c;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      rdy = cmd_ready;
      c   = cyc;
      tick();
      if (rdy) begin
        acc = c;
        break;
      end
    end
    cmd_valid = 1'b0;
    if (acc < 0) chk("cmd_accept_wait", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 100; i++) begin
      if (!busy && !rsp_valid && sb.size() == 0) return;
      tick();
    end
    chk(name, 64'd0, 64'd1);
  endtask

  task automatic clr_obs();
    awv_total = 0; wv_total = 0; arv_total = 0; rready_total = 0; b_hs_cnt = 0;
    awaddr_moves = 0;
    aw_hs_cyc = -1; w_hs_cyc = -1; b_hs_cyc = -1; ar_hs_cyc = -1;
    rsp_first_cyc = -1;
  endtask

  initial begin
    int   acc;
    logic seen;
    rst = 1'b1; rsp_ready = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
    repeat (3) tick();
    chk("reset_ctrl",
        64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
             rsp_valid, rsp_timeout, busy, cmd_ready}), 64'b000000001);
    chk("reset_data", 64'(rsp_rdata) | 64'(rsp_resp) | 64'(M_AXI_AWADDR) |
        64'(M_AXI_ARADDR) | 64'(M_AXI_WDATA), 64'd0);
    rst = 1'b0;
    tick();

    // 1: zero-wait write
    clr_obs();
    sb.push_back('{rdata: 32'h0, resp: 2'b00, to: 1'b0});
    issue(1'b1, 30'h0040_0004, 32'hDEAD_BEEF, 4'hF, acc);
    wait_done("wr0_done");
    chk("wr0_aw_hs_cyc", 64'(aw_hs_cyc - acc), 64'd1);
    chk("wr0_w_hs_cyc", 64'(w_hs_cyc - acc), 64'd1);
    chk("wr0_b_hs_cyc", 64'(b_hs_cyc - acc), 64'd2);
    chk("wr0_rsp_latency", 64'(rsp_first_cyc - acc), 64'd3);

    // 2: skewed write, AW held off for 5 cycles
    clr_obs();
    aw_delay = 5;
    sb.push_back('{rdata: 32'h0, resp: 2'b00, to: 1'b0});
    issue(1'b1, 30'h00C0_0010, 32'hA5A5_0F0F, 4'h3, acc);
    wait_done("wr1_done");
    chk("wr1_awvalid_cycles", 64'(awv_total), 64'd6);
    chk("wr1_wvalid_cycles", 64'(wv_total), 64'd1);
    chk("wr1_awaddr_stable", 64'(awaddr_moves), 64'd0);
    chk("wr1_b_handshakes", 64'(b_hs_cnt), 64'd1);
    aw_delay = 0;

    // 3: read with 3 wait cycles on R
    clr_obs();
    r_delay = 3; rdata_cfg = 32'h1234_5678;
    sb.push_back('{rdata: 32'h1234_5678, resp: 2'b00, to: 1'b0});
    issue(1'b0, 30'h0100_0000, 32'h0, 4'h0, acc);
    wait_done("rd0_done");
    chk("rd0_ar_hs_cyc", 64'(ar_hs_cyc - acc), 64'd1);
    chk("rd0_rready_cycles", 64'(rready_total), 64'd4);
    chk("rd0_rsp_latency", 64'(rsp_first_cyc - acc), 64'd6);
    r_delay = 0;

    // 4: SLVERR write with response backpressure, then back-to-back read
    clr_obs();
    bresp_cfg = 2'b10; rsp_ready = 1'b0;
    sb.push_back('{rdata: 32'h0, resp: 2'b10, to: 1'b0});
    issue(1'b1, 30'h0080_0020, 32'h0000_0001, 4'hF, acc);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin seen = 1'b1; break; end
      tick();
    end
    chk("bp_rsp_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold", 64'({rsp_valid, rsp_resp, cmd_ready}), 64'b1100);
      tick();
    end
    bresp_cfg = 2'b00; rsp_ready = 1'b1; rdata_cfg = 32'h0BAD_CAFE;
    sb.push_back('{rdata: 32'h0BAD_CAFE, resp: 2'b00, to: 1'b0});
    issue(1'b0, 30'h0100_0004, 32'h0, 4'h0, acc);
    chk("bp_next_accept", 64'(acc - rsp_hs_cyc), 64'd1);
    wait_done("bp_done");

    // 5: watchdog expiry on a slave that never takes AR
    clr_obs();
    ar_delay = 1000;
    sb.push_back('{rdata: 32'h0, resp: 2'b10, to: 1'b1});
    issue(1'b0, 30'h0100_0008, 32'h0, 4'h0, acc);
    wait_done("to_done");
    chk("to_arvalid_cycles", 64'(arv_total), 64'd17);
    chk("to_rsp_latency", 64'(rsp_first_cyc - acc), 64'd18);

    // 6: AR handshake in the expiry cycle completes normally
    clr_obs();
    ar_delay = 16; rdata_cfg = 32'h5555_AAAA;
    sb.push_back('{rdata: 32'h5555_AAAA, resp: 2'b00, to: 1'b0});
    issue(1'b0, 30'h0100_000C, 32'h0, 4'h0, acc);
    chk("to_flag_cleared", 64'(rsp_timeout), 64'd0);
    wait_done("edge_done");
    chk("edge_arvalid_cycles", 64'(arv_total), 64'd17);
    chk("edge_rsp_latency", 64'(rsp_first_cyc - acc), 64'd19);
    ar_delay = 0;

    // 7: reset while waiting in WR_RESP, then a clean read
    clr_obs();
    b_delay = 100;
    issue(1'b1, 30'h0040_0008, 32'hFFFF_0000, 4'hC, acc);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (M_AXI_BREADY) begin seen = 1'b1; break; end
      tick();
    end
    chk("rst_in_wr_resp", 64'(seen), 64'd1);
    rst = 1'b1;
    tick();
    chk("rst_abort",
        64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
             rsp_valid, busy, cmd_ready}), 64'b00000001);
    rst = 1'b0; b_delay = 0;
    tick();
    clr_obs();
    rdata_cfg = 32'hCAFE_F00D;
    sb.push_back('{rdata: 32'hCAFE_F00D, resp: 2'b00, to: 1'b0});
    issue(1'b0, 30'h0100_0010, 32'h0, 4'h0, acc);
    wait_done("post_rst_done");
    chk("post_rst_latency", 64'(rsp_first_cyc - acc), 64'd3);

    repeat (2) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
